// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and alignment rule shared by the load/store unit
package mem_access_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE, S_ERR} state_t;
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
      return (sz == SZ_ILL) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
   endfunction
endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge: little-endian sub-word store merge and load extraction
//   old_word/store_data/size/lane/load_unsigned in; merged (RAM write word), load_data (extended) out
module byte_lane_merge
   import mem_access_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] store_data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        load_unsigned,
   output logic [31:0] merged,
   output logic [31:0] load_data
);
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] b_mask;
   assign ld_b   = old_word[{lane, 3'b000} +: 8];
   assign ld_h   = lane[1] ? old_word[31:16] : old_word[15:0];
   assign b_mask = 32'hFF << {lane, 3'b000};
   assign merged = size == SZ_BYTE ? (old_word & ~b_mask) | ({24'b0, store_data[7:0]} << {lane, 3'b000}) :
                   size == SZ_HALF ? (lane[1] ? {store_data[15:0], old_word[15:0]} : {old_word[31:16], store_data[15:0]}) :
                   store_data;
   assign load_data = size == SZ_BYTE ? {{24{~load_unsigned & ld_b[7]}}, ld_b} :
                      size == SZ_HALF ? {{16{~load_unsigned & ld_h[15]}}, ld_h} :
                      old_word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a single-write-enable data RAM
//   CPU side: req_valid/mem_read/mem_write/addr/wdata/size/load_unsigned in; busy/done/rdata/misalign out
//   RAM side: ram_addr/ram_wdata/ram_memwrite out; ram_rdata in (one-cycle read latency)
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_memwrite,
   input  logic [31:0]       ram_rdata
);
   generate
      if (RD_LAT != 1) begin : g_bad_rd_lat
         $error("mem_access_unit supports only RD_LAT == 1");
      end
   endgenerate
   state_t            state;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       wdata_q, old_q, rdata_q, old_word, merged, load_data;
   logic [1:0]        size_q;
   logic              lu_q, write_q;
   logic              unused_addr_hi;
   // high address bits deliberately do not participate (no range fault)
   assign unused_addr_hi = ^addr[31:ADDR_W+2];
   assign busy         = state != S_IDLE;
   assign done         = state == S_DONE || state == S_ERR;
   assign misalign     = state == S_ERR;
   assign ram_memwrite = state == S_WRITE;
   assign ram_addr     = addr_q[ADDR_W+1:2];
   assign ram_wdata    = merged;
   assign rdata        = rdata_q;
   // in CAPTURE the buffer is being loaded this edge, so extract straight from the RAM
   assign old_word     = state == S_CAPTURE ? ram_rdata : old_q;
   byte_lane_merge u_merge (
      .old_word      (old_word),
      .store_data    (wdata_q),
      .size          (size_q),
      .lane          (addr_q[1:0]),
      .load_unsigned (lu_q),
      .merged        (merged),
      .load_data     (load_data)
   );
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         lu_q    <= 1'b0;
         write_q <= 1'b0;
         old_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (req_valid && (mem_read || mem_write)) begin
               addr_q  <= addr[ADDR_W+1:0];
               wdata_q <= wdata;
               size_q  <= size;
               lu_q    <= load_unsigned;
               write_q <= mem_write;
               if (misaligned(size, addr[1:0])) rdata_q <= '0;
               state   <= misaligned(size, addr[1:0]) ? S_ERR :
                          (mem_write && size == SZ_WORD) ? S_WRITE : S_READ;
            end
            S_READ: state <= S_CAPTURE;
            S_CAPTURE: begin
               old_q <= ram_rdata;
               if (!write_q) rdata_q <= load_data;
               state <= write_q ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
               rdata_q <= '0;
               state   <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store checks against a byte-level reference model
module tb_mem_access_unit;
   localparam int AW = 14;
   logic          clock = 1'b0, reset = 1'b1;
   logic          req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
   logic [31:0]   addr = '0, wdata = '0;
   logic [1:0]    size = '0;
   logic          busy, done, misalign, ram_memwrite;
   logic [31:0]   rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram [0:(1<<AW)-1];
   logic [31:0]   model [0:15];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_idx = '0;
   logic [31:0]   pre_data = '0;
   int            checks = 0, errors = 0;

   mem_access_unit #(.ADDR_W(AW), .RD_LAT(1)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .wdata(wdata), .size(size), .load_unsigned(load_unsigned), .busy(busy), .done(done),
      .rdata(rdata), .misalign(misalign), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_memwrite(ram_memwrite), .ram_rdata(ram_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      else if (ram_memwrite) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preset(input int idx, input logic [31:0] v);
      pre_idx = idx[AW-1:0];
      pre_data = v;
      pre_we = 1'b1;
      @(posedge clock); #1;
      pre_we = 1'b0;
      model[idx] = v;
   endtask

   function automatic logic is_fault(input logic [1:0] sz, input logic [31:0] a);
      int nb = 1 << sz;
      return sz == 2'b11 || (int'(a[1:0]) % nb) != 0;
   endfunction

   function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [1:0] sz);
      logic [31:0] r = old;
      for (int i = 0; i < (1 << sz); i++) r[(int'(a[1:0]) + i) * 8 +: 8] = wd[i * 8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] sz, input logic lu);
      int nb = 1 << sz;
      logic [31:0] v = old >> (8 * int'(a[1:0]));
      logic [31:0] m;
      if (nb < 4) begin
         m = (32'd1 << (8 * nb)) - 32'd1;
         v = v & m;
         if (!lu && v[8 * nb - 1]) v = v | ~m;
      end
      return v;
   endfunction

   task automatic txn(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic lu, input string tag);
      int idx = int'(a[5:2]);
      logic flt = is_fault(sz, a);
      int lat = flt ? 1 : wr ? (sz == 2'b10 ? 2 : 4) : 3;
      int exp_nw = (!flt && wr) ? 1 : 0;
      logic [31:0] exp_w = exp_store(model[idx], a, wd, sz);
      logic [31:0] exp_r = (!flt && !wr) ? exp_load(model[idx], a, sz, lu) : 32'd0;
      int n = 0, nw = 0, wn = 0, dn = 0;
      logic mis = 1'b0;
      logic [31:0] ro = '0, wdat = '0;
      logic [AW-1:0] waddr = '0;
      req_valid = 1'b1; mem_write = wr; mem_read = rd; addr = a; wdata = wd; size = sz; load_unsigned = lu;
      while (dn == 0 && n < 12) begin
         @(posedge clock); #1;
         n++;
         if (ram_memwrite) begin nw++; wn = n; waddr = ram_addr; wdat = ram_wdata; end
         if (done) begin dn = n; mis = misalign; ro = rdata; end
      end
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      chk({tag, "_done_cycle"}, dn, lat);
      chk({tag, "_misalign"}, {31'b0, mis}, {31'b0, flt});
      chk({tag, "_writes"}, nw, exp_nw);
      chk({tag, "_rdata"}, ro, exp_r);
      if (exp_nw == 1) begin
         chk({tag, "_write_cycle"}, wn, lat - 1);
         chk({tag, "_ram_addr"}, {18'b0, waddr}, {18'b0, a[15:2]});
         chk({tag, "_ram_wdata"}, wdat, exp_w);
         model[idx] = exp_w;
      end
      @(posedge clock); #1;
      chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
      chk({tag, "_ram_word"}, ram[idx], model[idx]);
   endtask

   initial begin
      int nw;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
      chk("rst_memwrite", {31'b0, ram_memwrite}, 32'd0);
      chk("rst_ram_addr", {18'b0, ram_addr}, 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) preset(i, $urandom);

      txn(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, "word_store");
      chk("word_store_value", ram[4], 32'hDEAD_BEEF);
      preset(4, 32'h1122_3344);
      txn(1'b1, 1'b0, 32'h0000_0013, 32'h0000_00AB, 2'b00, 1'b0, "byte_store");
      chk("byte_store_value", ram[4], 32'hAB22_3344);
      preset(4, 32'h8001_7FFF);
      txn(1'b0, 1'b1, 32'h0000_0012, 32'h0, 2'b01, 1'b0, "half_load_s");
      txn(1'b0, 1'b1, 32'h0000_0012, 32'h0, 2'b01, 1'b1, "half_load_u");
      preset(4, 32'h1122_3380);
      txn(1'b0, 1'b1, 32'h0000_0010, 32'h0, 2'b00, 1'b0, "byte_load_s");
      txn(1'b1, 1'b0, 32'h0000_0012, 32'h5555_5555, 2'b10, 1'b0, "fault_word");
      txn(1'b0, 1'b1, 32'h0000_0011, 32'h0, 2'b01, 1'b0, "fault_half");
      txn(1'b1, 1'b0, 32'h0000_0010, 32'h6666_6666, 2'b11, 1'b0, "fault_size");
      txn(1'b1, 1'b1, 32'hFFFF_0018, 32'h0BAD_F00D, 2'b10, 1'b0, "high_bits_store");

      req_valid = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = 32'h20; size = 2'b10;
      nw = 0;
      repeat (3) begin @(posedge clock); #1; if (busy) nw++; end
      req_valid = 1'b0;
      chk("ignored_req_busy", nw, 0);

      preset(5, 32'hCAFE_BABE);
      req_valid = 1'b1; mem_write = 1'b1; addr = 32'h0000_0014; wdata = 32'h55; size = 2'b00;
      repeat (3) begin @(posedge clock); #1; end
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_memwrite", {31'b0, ram_memwrite}, 32'd0);
      req_valid = 1'b0; mem_write = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      nw = 0;
      repeat (5) begin @(posedge clock); #1; if (ram_memwrite) nw++; end
      chk("rst_mid_no_write", nw, 0);
      chk("rst_mid_ram", ram[5], 32'hCAFE_BABE);
      txn(1'b0, 1'b1, 32'h0000_0014, 32'h0, 2'b10, 1'b0, "post_rst_load");

      for (int k = 0; k < 150; k++) begin
         logic [31:0] a = {16'($urandom), 10'b0, 6'($urandom)};
         logic w = 1'($urandom);
         txn(w, ~w | 1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
